// File: rtl/dhdw_grad_accum_pkg.sv
// rtl/dhdw_grad_accum_pkg.sv - shared widths, saturation limits, FSM states and saturation helper
package dhdw_grad_accum_pkg;

    localparam int DATABIT = 16;
    localparam int FRAC    = 12;
    localparam int ACCBIT  = 32;
    localparam int CELLNUM = 4;
    localparam int QBIT    = 2 * DATABIT - FRAC;

    localparam logic signed [DATABIT-1:0] SAT_MAX = {1'b0, {(DATABIT-1){1'b1}}};
    localparam logic signed [DATABIT-1:0] SAT_MIN = {1'b1, {(DATABIT-1){1'b0}}};
    localparam logic signed [ACCBIT-1:0]  ACC_MAX = {{(ACCBIT-DATABIT+1){1'b0}}, {(DATABIT-1){1'b1}}};
    localparam logic signed [ACCBIT-1:0]  ACC_MIN = ~ACC_MAX;

    typedef enum logic [2:0] {
        IDLE, RUN, MAC0, MAC1, MAC2, MAC3, UPDATE, DONE
    } state_t;

    function automatic logic signed [DATABIT-1:0] sat(input logic signed [ACCBIT-1:0] v);
        if (v > ACC_MAX)
            return SAT_MAX;
        else if (v < ACC_MIN)
            return SAT_MIN;
        else
            return v[DATABIT-1:0];
    endfunction

endpackage

// File: rtl/dhdw_grad_accum_q_mul.sv
// rtl/dhdw_grad_accum_q_mul.sv - signed fixed-point multiply, floor-shifted by FRAC
module dhdw_grad_accum_q_mul
    import dhdw_grad_accum_pkg::*;
(
    input  logic signed [DATABIT-1:0] a,
    input  logic signed [DATABIT-1:0] b,
    output logic signed [QBIT-1:0]    y
);

    logic signed [2*DATABIT-1:0] prod;

    assign prod = a * b;
    // Dropping the low FRAC bits of a two's-complement product is an arithmetic shift (floor).
    assign y = prod[2*DATABIT-1:FRAC];

endmodule

// File: rtl/dhdw_grad_accum.sv
// rtl/dhdw_grad_accum.sv - dh/dw recurrent state holder and per-sequence gradient/weight update
module dhdw_grad_accum
    import dhdw_grad_accum_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      seq_start,
    input  logic [7:0]                seq_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATABIT-1:0] dh0,
    input  logic signed [DATABIT-1:0] dh1,
    input  logic signed [DATABIT-1:0] dh2,
    input  logic signed [DATABIT-1:0] dh3,
    input  logic signed [DATABIT-1:0] err0,
    input  logic signed [DATABIT-1:0] err1,
    input  logic signed [DATABIT-1:0] err2,
    input  logic signed [DATABIT-1:0] err3,
    input  logic signed [DATABIT-1:0] lr,
    input  logic signed [DATABIT-1:0] w_in,
    output logic signed [DATABIT-1:0] dh0_dw,
    output logic signed [DATABIT-1:0] dh1_dw,
    output logic signed [DATABIT-1:0] dh2_dw,
    output logic signed [DATABIT-1:0] dh3_dw,
    output logic signed [DATABIT-1:0] grad,
    output logic signed [DATABIT-1:0] w_upd,
    output logic                      upd_valid,
    output logic                      drop_err
);

    state_t                    state;
    logic [7:0]                cnt;
    logic [7:0]                len_eff;
    logic signed [DATABIT-1:0] dh_r  [CELLNUM];
    logic signed [DATABIT-1:0] err_r [CELLNUM];
    logic signed [ACCBIT-1:0]  acc;
    logic [1:0]                sel;
    logic signed [QBIT-1:0]    mac_p;
    logic signed [QBIT-1:0]    upd_p;
    logic signed [DATABIT-1:0] grad_s;
    logic signed [ACCBIT-1:0]  w_diff;
    logic                      busy;
    logic                      in_mac;

    always_comb begin
        sel = 2'd0;
        case (state)
            MAC1:    sel = 2'd1;
            MAC2:    sel = 2'd2;
            MAC3:    sel = 2'd3;
            default: sel = 2'd0;
        endcase
    end

    assign in_mac = (state == MAC0) || (state == MAC1) || (state == MAC2) || (state == MAC3);
    assign busy   = in_mac || (state == UPDATE) || (state == DONE);
    assign grad_s = sat(acc);
    assign w_diff = ACCBIT'(w_in) - ACCBIT'(upd_p);

    // One multiplier walks the four cells across MAC0..MAC3; the other scales the gradient.
    dhdw_grad_accum_q_mul u_mac (.a(err_r[sel]), .b(dh_r[sel]), .y(mac_p));
    dhdw_grad_accum_q_mul u_upd (.a(lr),         .b(grad_s),    .y(upd_p));

    assign dh0_dw = dh_r[0];
    assign dh1_dw = dh_r[1];
    assign dh2_dw = dh_r[2];
    assign dh3_dw = dh_r[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            upd_valid <= 1'b0;
            drop_err  <= 1'b0;
            grad      <= '0;
            w_upd     <= '0;
            acc       <= '0;
            cnt       <= '0;
            len_eff   <= 8'd1;
            for (int i = 0; i < CELLNUM; i++) begin
                dh_r[i]  <= '0;
                err_r[i] <= '0;
            end
        end else begin
            upd_valid <= 1'b0;
            // A new sequence overrides whatever is in flight, including a same-cycle sample.
            if (seq_start) begin
                state    <= RUN;
                in_ready <= 1'b1;
                acc      <= '0;
                cnt      <= '0;
                drop_err <= 1'b0;
                len_eff  <= (seq_len == 8'd0) ? 8'd1 : seq_len;
                for (int i = 0; i < CELLNUM; i++)
                    dh_r[i] <= '0;
            end else begin
                if (in_valid && busy)
                    drop_err <= 1'b1;
                if (in_mac)
                    acc <= acc + ACCBIT'(mac_p);
                case (state)
                    IDLE: in_ready <= 1'b0;
                    RUN: begin
                        if (in_valid) begin
                            dh_r[0]  <= dh0;
                            dh_r[1]  <= dh1;
                            dh_r[2]  <= dh2;
                            dh_r[3]  <= dh3;
                            err_r[0] <= err0;
                            err_r[1] <= err1;
                            err_r[2] <= err2;
                            err_r[3] <= err3;
                            cnt      <= cnt + 8'd1;
                            in_ready <= 1'b0;
                            state    <= MAC0;
                        end
                    end
                    MAC0: state <= MAC1;
                    MAC1: state <= MAC2;
                    MAC2: state <= MAC3;
                    MAC3: begin
                        if (cnt == len_eff) begin
                            state <= UPDATE;
                        end else begin
                            state    <= RUN;
                            in_ready <= 1'b1;
                        end
                    end
                    UPDATE: begin
                        grad      <= grad_s;
                        w_upd     <= sat(w_diff);
                        upd_valid <= 1'b1;
                        state     <= DONE;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/dhdw_grad_accum.md
# dhdw_grad_accum

Downstream stage of the GRU hidden-layer derivative pipeline. It consumes the per-timestep dh/dw vector (4 cells) and the output-layer error vector. It holds dh/dw as recurrent state, fed back as the dh*_dw inputs for the next timestep. It also accumulates the gradient g = Σ_t Σ_i err_i·dh_i/dw over a sequence and emits one saturated weight update per sequence.

## Interface
- DATABIT, 16, data width, signed fixed point
- FRAC, 12, fractional bits (Q3.12)
- ACCBIT, 32, accumulator width
- CELLNUM, 4, hidden cells (fixed at 4 for this block)
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- seq_start  in  1  pulse: start new sequence (any state)
- seq_len  in  8  timesteps per sequence, sampled on seq_start; 0 treated as 1
- in_valid  in  1  dh/err sample valid
- in_ready  out  1  block can accept a sample
- dh0..dh3  in  DATABIT  signed dh_i/dw from upstream
- err0..err3  in  DATABIT  signed output error per cell
- lr  in  DATABIT  signed learning rate, sampled in UPDATE
- w_in  in  DATABIT  signed current weight, sampled in UPDATE
- dh0_dw..dh3_dw  out  DATABIT  recurrent dh/dw state fed back upstream
- grad  out  DATABIT  saturated sequence gradient
- w_upd  out  DATABIT  saturated w_in − lr·grad
- upd_valid  out  1  one-cycle pulse: grad/w_upd are new
- drop_err  out  1  sticky: sample offered while not ready

## Operation
- FSM: IDLE → (seq_start) RUN → (accept) MAC0..MAC3 → RUN if more timesteps, else UPDATE → DONE → IDLE.
- in_ready = 1 only in RUN. A sample is accepted when in_valid & in_ready.
- On accept:
  - dh0..3 and err0..3 are registered.
  - dh*_dw outputs take the new dh values.
  - The timestep counter increments.
- MACk: acc += (err_k · dh_k) >>> FRAC. The product is a full 2·DATABIT signed value. The arithmetic shift truncates toward −∞. The sign-extended sum goes into ACCBIT and cannot overflow for 255×4 terms.
- After MAC3: go to UPDATE if the counter equals the effective seq_len, else go to RUN.
- UPDATE:
  - grad ← sat(acc).
  - w_upd ← sat(w_in − ((lr · sat(acc)) >>> FRAC)).
  - sat clamps to [−2^(DATABIT−1), 2^(DATABIT−1)−1].
- DONE: upd_valid = 1 for exactly this cycle. grad and w_upd hold until the next UPDATE.
- seq_start, in any state, including MAC and UPDATE:
  - Next state is RUN.
  - acc, counter, dh*_dw and drop_err clear to 0.
  - seq_len is resampled.
  - No upd_valid is produced for the aborted sequence.
- seq_start takes priority over a same-cycle accept. The sample is discarded and drop_err is not set.
- drop_err sets when in_valid = 1 in MAC*, UPDATE or DONE. That sample is ignored. drop_err clears only on rst or seq_start.
- in_valid in IDLE is ignored silently.

## Timing
- Reset values:
  - state IDLE
  - in_ready 0, upd_valid 0, drop_err 0
  - dh*_dw 0, grad 0, w_upd 0
  - acc 0, counter 0
- Accept on edge E0: dh*_dw are valid after E0; MAC0–MAC3 occupy E1–E4.
- Intermediate timestep: in_ready is high again after E4. Throughput is one sample per 5 cycles.
- Last timestep:
  - UPDATE state follows E4.
  - grad and w_upd are registered at E5, and upd_valid is high after E5 for one cycle.
  - The block is back in IDLE after E6.
- dh*_dw is stable from one accept edge to the next. Upstream may sample it any time in RUN.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package (next to the existing parameter include): DATABIT, FRAC, ACCBIT, CELLNUM, SAT_MAX/SAT_MIN constants, and the FSM state enum (IDLE, RUN, MAC0–MAC3, UPDATE, DONE).
- One sub-module, q_mul: signed DATABIT×DATABIT multiply with arithmetic shift by FRAC, combinational, output 2·DATABIT−FRAC bits. Two instances: one time-multiplexed over MAC0–MAC3, and one for lr·grad.
- Saturation is a package function.

## Test plan
- Reset: assert rst for 2 cycles mid-MAC → all outputs 0, state IDLE, in_ready 0 on the following cycle.
- seq_len=1, err0..3=4096, dh=2048/1024/−512/0, lr=4096, w_in=8192 → dh0..3_dw=2048/1024/−512/0 after E0, grad=2560 and w_upd=5632 with upd_valid high exactly after E5.
- seq_len=3, three samples of err=4096 all cells and dh=(256,0,0,0) (first sample), (0,512,0,0) (second), (0,0,0,−1024) (third) → in_ready low for 4 cycles after each accept, dh*_dw track the last sample, final grad=−256.
- Saturation: seq_len=1, err=dh=32767 on all cells, w_in=−32768, lr=4096 → grad=32767, w_upd=−32768.
- in_valid asserted during MAC2 → drop_err=1 and stays 1, acc unaffected, next RUN sample is accepted normally.
- seq_start during MAC2 with nonzero acc → next cycle RUN, dh*_dw=0, acc=0, drop_err=0, no upd_valid for the aborted sequence; a new seq_len=1 run then gives the correct grad.
